// File: rtl/aes_encryptor_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes_sbox / aes_encryptor_top
// Description : Iterative AES-128 encryptor. One round per clock with an
//               on-the-fly key schedule. Fixed 10-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_sbox: forward S-box as the multiplicative inverse in GF(2^8) (x^254),
// followed by the affine transform. Purely combinational.
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128, w_inv;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally
    always_comb begin
        w_x2     = gf_mul(in_byte, in_byte);
        w_x4     = gf_mul(w_x2, w_x2);
        w_x8     = gf_mul(w_x4, w_x4);
        w_x16    = gf_mul(w_x8, w_x8);
        w_x32    = gf_mul(w_x16, w_x16);
        w_x64    = gf_mul(w_x32, w_x32);
        w_x128   = gf_mul(w_x64, w_x64);
        w_inv    = gf_mul(gf_mul(gf_mul(w_x2, w_x4), gf_mul(w_x8, w_x16)),
                          gf_mul(gf_mul(w_x32, w_x64), w_x128));
        out_byte = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;
    end
endmodule

// ----------------------------------------------------------------------------
// aes_encryptor_top. Byte i of a 128-bit word sits at bits [127-8i -: 8];
// the AES state is column-major, so byte i is row i%4, column i/4.
// ----------------------------------------------------------------------------
module aes_encryptor_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         valid,
    output logic [127:0] ciphertext_out
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_busy;
    logic         r_valid;
    logic [127:0] r_ct;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [31:0]  w_ksub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_temp;
    logic [127:0] w_next_key;
    logic [127:0] w_round_out;

    // SubBytes: 16 S-boxes on the round state
    generate
        for (genvar i = 0; i < 16; i++) begin : g_sub
            aes_sbox u_sbox (.in_byte(r_state[127-8*i -: 8]), .out_byte(w_sub[127-8*i -: 8]));
        end
    endgenerate

    // ShiftRows: row r rotates left by r columns
    generate
        for (genvar c = 0; c < 4; c++) begin : g_shift_col
            for (genvar r = 0; r < 4; r++) begin : g_shift_row
                assign w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    endgenerate

    // MixColumns on each column
    generate
        for (genvar c = 0; c < 4; c++) begin : g_mix
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_shift[127-32*c -: 8];
            assign w_a1 = w_shift[119-32*c -: 8];
            assign w_a2 = w_shift[111-32*c -: 8];
            assign w_a3 = w_shift[103-32*c -: 8];
            assign w_mix[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign w_mix[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign w_mix[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign w_mix[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

    // Key schedule SubWord: S-boxes on the last word; RotWord is applied after
    generate
        for (genvar i = 0; i < 4; i++) begin : g_ksub
            aes_sbox u_sbox (.in_byte(r_key[31-8*i -: 8]), .out_byte(w_ksub[31-8*i -: 8]));
        end
    endgenerate

    // Round constant for the round being computed
    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1B;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Next round key and the complete round result
    always_comb begin
        w_temp                 = {w_ksub[23:0], w_ksub[31:24]} ^ {w_rcon, 24'h000000};
        w_next_key[127:96]     = r_key[127:96] ^ w_temp;
        w_next_key[95:64]      = r_key[95:64]  ^ w_next_key[127:96];
        w_next_key[63:32]      = r_key[63:32]  ^ w_next_key[95:64];
        w_next_key[31:0]       = r_key[31:0]   ^ w_next_key[63:32];
        w_round_out            = ((r_round == c_LAST_ROUND) ? w_shift : w_mix) ^ w_next_key;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ct    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_state <= plaintext ^ key;
                        r_key   <= key;
                        r_round <= 4'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_round_out;
                    r_key   <= w_next_key;
                    if (r_round == c_LAST_ROUND) begin
                        r_ct    <= w_round_out;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_round <= 4'd0;
                        r_fsm   <= IDLE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign valid          = r_valid;
    assign ciphertext_out = r_ct;
endmodule
`default_nettype wire
